// File: rtl/tpu_result_serializer.sv
// Result tile serializer: captures a tile of accumulators from the systolic array
// into a pending buffer, then streams it out one byte per valid/ready handshake.
// A second tile may be captured while the active one drains.
//
// state | meaning
// IDLE  | no active tile; loads the pending tile as soon as one is held
// SEND  | active tile draining; out_valid high until the last byte is accepted
module tpu_result_serializer #(
    parameter int NUM_ELEMS = 4,
    parameter int ACC_W     = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       res_valid,
    input  logic [NUM_ELEMS*ACC_W-1:0] res_data,
    output logic                       res_ready,
    output logic [7:0]                 out_byte,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       tile_done
);

    localparam int TILE_W = NUM_ELEMS * ACC_W;
    localparam int BPE    = ACC_W / 8;
    localparam int NB     = TILE_W / 8;
    localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic [TILE_W-1:0]   pend_buf_q,  pend_buf_d;
    logic                pend_full_q, pend_full_d;
    logic [TILE_W-1:0]   act_buf_q,   act_buf_d;
    logic [IDX_W-1:0]    byte_idx_q,  byte_idx_d;
    logic                out_valid_q, out_valid_d;
    logic                tile_done_q, tile_done_d;

    logic [7:0]          byte_arr [NB];

    // Reorder the active tile into transmit order so the output is a plain index.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            byte_arr[b] = act_buf_q[(b / BPE) * ACC_W
                                    + 8 * ((MSB_FIRST != 0) ? (BPE - 1 - (b % BPE)) : (b % BPE)) +: 8];
        end
    end

    // Next-state logic: tile capture into the pending buffer plus the drain FSM.
    always_comb begin
        state_d     = state_q;
        pend_buf_d  = pend_buf_q;
        pend_full_d = pend_full_q;
        act_buf_d   = act_buf_q;
        byte_idx_d  = byte_idx_q;
        out_valid_d = out_valid_q;
        tile_done_d = 1'b0;

        // Capture only into an empty pending buffer; a reload below only happens
        // when it is full, so the two never touch pend_full in the same cycle.
        if (res_valid && !pend_full_q) begin
            pend_buf_d  = res_data;
            pend_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    act_buf_d   = pend_buf_q;
                    pend_full_d = 1'b0;
                    byte_idx_d  = '0;
                    state_d     = SEND;
                    out_valid_d = 1'b1;
                end
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    if (byte_idx_q == LAST_IDX) begin
                        tile_done_d = 1'b1;
                        if (pend_full_q) begin
                            // Back-to-back reload keeps out_valid high with no bubble.
                            act_buf_d   = pend_buf_q;
                            pend_full_d = 1'b0;
                            byte_idx_d  = '0;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any held tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_buf_q  <= '0;
            pend_full_q <= 1'b0;
            act_buf_q   <= '0;
            byte_idx_q  <= '0;
            out_valid_q <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_buf_q  <= pend_buf_d;
            pend_full_q <= pend_full_d;
            act_buf_q   <= act_buf_d;
            byte_idx_q  <= byte_idx_d;
            out_valid_q <= out_valid_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign res_ready = !pend_full_q;
    assign busy      = (state_q == SEND) || pend_full_q;
    assign out_valid = out_valid_q;
    assign tile_done = tile_done_q;
    assign out_byte  = byte_arr[byte_idx_q];

endmodule

// File: tb/tb_tpu_result_serializer.sv
// Testbench for tpu_result_serializer: a table of known tiles, hand-written
// corner sequences and a randomized phase, all checked against a tile/byte queue model.
module tb_tpu_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid;
    logic [63:0] res_data;
    logic        out_ready;

    logic        res_ready_l, out_valid_l, busy_l, tile_done_l;
    logic [7:0]  out_byte_l;
    logic        res_ready_m, out_valid_m, busy_m, tile_done_m;
    logic [7:0]  out_byte_m;

    int checks = 0;
    int errors = 0;

    tpu_result_serializer #(.NUM_ELEMS(4), .ACC_W(16), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready_l), .out_byte(out_byte_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .busy(busy_l), .tile_done(tile_done_l)
    );

    tpu_result_serializer #(.NUM_ELEMS(4), .ACC_W(16), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready_m), .out_byte(out_byte_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .busy(busy_m), .tile_done(tile_done_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte b of a tile in transmit order: element b/2, low byte first unless msb.
    function automatic logic [7:0] ref_byte(input logic [63:0] tile, input int b, input bit msb);
        logic [15:0] v;
        int          s;
        v = tile[(b / 2) * 16 +: 16];
        s = b % 2;
        if (msb) s = 1 - s;
        return 8'((v >> (8 * s)) & 16'h00FF);
    endfunction

    // ---------------- reference model: queues of bytes still owed ----------------
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         popped;
    bit         done_exp;
    bit         from_empty;

    always @(negedge clk) begin
        int tiles;
        bit pend;
        if (rst) begin
            qa.delete();
            qb.delete();
            popped     = 0;
            done_exp   = 0;
            from_empty = 0;
        end else begin
            tiles = (qa.size() + 7) / 8;
            pend  = (tiles >= 2) || (tiles == 1 && !out_valid_l);
            chk("mon_busy", busy_l, qa.size() != 0);
            chk("mon_busy_m", busy_m, qb.size() != 0);
            chk("mon_res_ready", res_ready_l, !pend);
            chk("mon_res_ready_m", res_ready_m, !pend);
            chk("mon_tile_done", tile_done_l, done_exp);
            chk("mon_tile_done_m", tile_done_m, done_exp);
            chk("mon_out_valid", out_valid_l, (qa.size() != 0) && !from_empty);
            chk("mon_out_valid_m", out_valid_m, (qb.size() != 0) && !from_empty);
            if (out_valid_l && qa.size() != 0) begin
                chk("mon_byte", out_byte_l, qa[0]);
                chk("mon_byte_m", out_byte_m, qb[0]);
            end
            done_exp   = 0;
            from_empty = 0;
            if (out_valid_l && out_ready && qa.size() != 0) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                popped++;
                if (popped % 8 == 0) done_exp = 1;
            end
            if (res_valid && res_ready_l) begin
                from_empty = (qa.size() == 0);
                for (int b = 0; b < 8; b++) begin
                    qa.push_back(ref_byte(res_data, b, 1'b0));
                    qb.push_back(ref_byte(res_data, b, 1'b1));
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0]      tile;
        logic [0:7][7:0]  exp_l;
        logic [0:7][7:0]  exp_m;
    } vec_t;

    vec_t tbl[3];

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_l) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wait_idle_timeout", busy_l, 1'b0);
    endtask

    task automatic run_entry(input int i);
        @(posedge clk); #1;
        res_valid = 1'b1;
        res_data  = tbl[i].tile;
        out_ready = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("tbl%0d_latency_valid", i), out_valid_l, 1'b0);
        chk($sformatf("tbl%0d_latency_busy", i), busy_l, 1'b1);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_valid_b%0d", i, b), out_valid_l, 1'b1);
            chk($sformatf("tbl%0d_lsb_b%0d", i, b), out_byte_l, tbl[i].exp_l[b]);
            chk($sformatf("tbl%0d_msb_b%0d", i, b), out_byte_m, tbl[i].exp_m[b]);
        end
        @(negedge clk);
        chk($sformatf("tbl%0d_tile_done", i), tile_done_l, 1'b1);
        chk($sformatf("tbl%0d_valid_drop", i), out_valid_l, 1'b0);
    endtask

    initial begin
        logic [7:0] got_q[$];
        logic [7:0] prev_byte;
        bit         prev_stall;
        int         got;

        tbl[0].tile  = {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234};
        tbl[0].exp_l = {8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
        tbl[0].exp_m = {8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
        tbl[1].tile  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tbl[1].exp_l = {8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        tbl[1].exp_m = {8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        tbl[2].tile  = {16'h7FFE, 16'h8001, 16'hFF00, 16'h00FF};
        tbl[2].exp_l = {8'hFF, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hFE, 8'h7F};
        tbl[2].exp_m = {8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h01, 8'h7F, 8'hFE};

        rst       = 1'b1;
        res_valid = 1'b0;
        res_data  = '0;
        out_ready = 1'b0;
        #2;
        chk("reset_out_valid", out_valid_l, 1'b0);
        chk("reset_out_byte", out_byte_l, 8'h00);
        chk("reset_res_ready", res_ready_l, 1'b1);
        chk("reset_busy", busy_l, 1'b0);
        chk("reset_tile_done", tile_done_l, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // T1/T2 and extra patterns from the table
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            run_entry(i);
        end

        // T3: stalls hold the byte, nothing skipped or repeated
        wait_idle();
        @(posedge clk); #1;
        res_valid = 1'b1;
        res_data  = tbl[0].tile;
        out_ready = 1'b0;
        @(posedge clk); #1;
        res_valid  = 1'b0;
        got        = 0;
        prev_stall = 0;
        prev_byte  = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if (out_valid_l) begin
                if (prev_stall) chk("t3_stall_hold", out_byte_l, prev_byte);
                if (out_ready) begin
                    chk($sformatf("t3_seq_b%0d", got), out_byte_l, tbl[0].exp_l[got]);
                    got++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_byte  = out_byte_l;
                end
            end
            @(posedge clk); #1;
            out_ready = (c % 3 == 0);
        end
        chk("t3_byte_count", got, 8);
        out_ready = 1'b1;

        // T4: second tile mid-drain, back-to-back, third tile stalls
        wait_idle();
        @(posedge clk); #1;
        res_valid = 1'b1;
        res_data  = tbl[0].tile;
        out_ready = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        got_q.delete();
        for (int c = 0; c < 19; c++) begin
            int n;
            @(negedge clk);
            if (c == 3) chk("t4_ready_tile2", res_ready_l, 1'b1);
            if (c >= 4 && c <= 8) chk("t4_ready_stall", res_ready_l, 1'b0);
            if (c == 9) chk("t4_ready_after_reload", res_ready_l, 1'b1);
            if (c >= 1 && c <= 16) chk("t4_no_bubble", out_valid_l, 1'b1);
            if (out_valid_l && out_ready) got_q.push_back(out_byte_l);
            @(posedge clk); #1;
            n = c + 1;
            res_valid = (n >= 3 && n <= 6);
            res_data  = (n == 3) ? tbl[1].tile : 64'h5555_6666_7777_8888;
        end
        res_valid = 1'b0;
        chk("t4_byte_count", got_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_byte%0d", i), got_q[i],
                (i < 8) ? tbl[0].exp_l[i] : tbl[1].exp_l[i - 8]);
        end

        // T5: reset mid-tile
        wait_idle();
        @(posedge clk); #1;
        res_valid = 1'b1;
        res_data  = tbl[0].tile;
        out_ready = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_byte3", out_byte_l, 8'hAB);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid_l, 1'b0);
        chk("t5_rst_res_ready", res_ready_l, 1'b1);
        chk("t5_rst_busy", busy_l, 1'b0);
        chk("t5_rst_tile_done", tile_done_l, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_no_tile_done", tile_done_l, 1'b0);
            chk("t5_idle_busy", busy_l, 1'b0);
        end
        run_entry(1);

        // T6: host stalled for 20 cycles with res_valid held
        wait_idle();
        @(posedge clk); #1;
        out_ready = 1'b0;
        res_valid = 1'b1;
        res_data  = tbl[0].tile;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("t6_out_valid", out_valid_l, 1'b1);
                chk("t6_byte0_held", out_byte_l, 8'h34);
                chk("t6_busy", busy_l, 1'b1);
                chk("t6_no_tile_done", tile_done_l, 1'b0);
            end
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Randomized traffic checked by the queue model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            res_valid = ($urandom_range(0, 3) == 0);
            res_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 4) != 0);
        end
        @(posedge clk); #1;
        res_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
